// File: rtl/regfile_wb_arb.sv
// Round-robin writeback arbiter for the register-file write port, with starvation override.
// Define REGFILE_WB_BYPASS_EN to add same-cycle forwarding of the in-flight write to two read ports.
module regfile_wb_arb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [AW-1:0]   byp_addr_1,
  input  logic [AW-1:0]   byp_addr_2,
  input  logic [XLEN-1:0] rf_data_1,
  input  logic [XLEN-1:0] rf_data_2,
  output logic [XLEN-1:0] byp_data_1,
  output logic [XLEN-1:0] byp_data_2,
`endif
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            conflict
);

  localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

  logic            rr_q, rr_d;
  logic [3:0]      w0_q, w0_d, w1_q, w1_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            conflict_q, conflict_d;

  logic            grant0, grant1, grant_any;
  logic            starve0, starve1;
  logic [AW-1:0]   gnt_addr;
  logic [XLEN-1:0] gnt_data;

  assign starve0 = (w0_q >= MAX_WAIT_W);
  assign starve1 = (w1_q >= MAX_WAIT_W);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !hold) begin
      if (req0_valid && !req1_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid && !req0_valid) begin
        grant1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
        if (starve0 && !starve1)      grant0 = 1'b1;
        else if (starve1 && !starve0) grant1 = 1'b1;
        else if (rr_q)                grant1 = 1'b1;
        else                          grant0 = 1'b1;
      end
    end
  end

  assign grant_any  = grant0 | grant1;
  assign gnt_addr   = grant1 ? req1_addr : req0_addr;
  assign gnt_data   = grant1 ? req1_data : req0_data;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    rr_d = rr_q;
    if (grant0) rr_d = 1'b1;
    if (grant1) rr_d = 1'b0;

    w0_d = w0_q;
    if (!req0_valid || grant0) w0_d = 4'd0;
    else if (w0_q != 4'hF)     w0_d = w0_q + 4'd1;

    w1_d = w1_q;
    if (!req1_valid || grant1) w1_d = 4'd0;
    else if (w1_q != 4'hF)     w1_d = w1_q + 4'd1;

    // x0 still completes the handshake and loads addr/data, but never enables the write
    wr_en_d   = grant_any && (gnt_addr != '0);
    wr_addr_d = grant_any ? gnt_addr : wr_addr_q;
    wr_data_d = grant_any ? gnt_data : wr_data_q;

    conflict_d = req0_valid && req1_valid && (req0_addr == req1_addr) && (req0_addr != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      w0_q       <= 4'd0;
      w1_q       <= 4'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign conflict = conflict_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_data_1 = (wr_en_q && (wr_addr_q == byp_addr_1) && (byp_addr_1 != '0)) ? wr_data_q : rf_data_1;
  assign byp_data_2 = (wr_en_q && (wr_addr_q == byp_addr_2) && (byp_addr_2 != '0)) ? wr_data_q : rf_data_2;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb (MAX_WAIT=2); bypass checks build only with REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arb;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            hold = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [AW-1:0]   req0_addr = '0, req1_addr = '0;
  logic [XLEN-1:0] req0_data = '0, req1_data = '0;
  logic            wr_en, conflict;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0]   byp_addr_1 = '0, byp_addr_2 = '0;
  logic [XLEN-1:0] rf_data_1 = '0, rf_data_2 = '0;
  logic [XLEN-1:0] byp_data_1, byp_data_2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arb #(.XLEN(XLEN), .AW(AW), .MAX_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .conflict(conflict)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h1111_0000;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2222_0000;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    @(negedge clk);
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b exp 0", conflict); end
    rst_n = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_first_grant got %b exp 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL reset_conflict_after got %b exp 1", conflict); end
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'h1111_0000) begin
      errors++; $display("FAIL reset_first_write got en=%b addr=%0d data=%h exp en=1 addr=4 data=11110000", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hDEAD_BEEF;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef", wr_en, wr_addr, wr_data); end
    @(negedge clk);
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_idle got en=%b addr=%0d data=%h exp en=0 addr=5 data=deadbeef", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_round_robin();
    logic exp1, prev1;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA0A0_0001;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB0B0_0002;
    prev1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp1 = (i % 2) == 1;
      checks++; if ({req0_ready, req1_ready} !== {~exp1, exp1}) begin
        errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, {req0_ready, req1_ready}, {~exp1, exp1}); end
      if (i > 0) begin
        checks++; if (wr_en !== 1'b1 || wr_addr !== (prev1 ? 5'd2 : 5'd1)) begin
          errors++; $display("FAIL rr_write[%0d] got en=%b addr=%0d exp en=1 addr=%0d", i, wr_en, wr_addr, prev1 ? 2 : 1); end
      end
      prev1 = exp1;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd2 || wr_data !== 32'hB0B0_0002) begin
      errors++; $display("FAIL rr_last got en=%b addr=%0d data=%h exp en=1 addr=2 data=b0b00002", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h0000_1234;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_data !== 32'h0000_1234) begin errors++; $display("FAIL x0_wr_data got %h exp 00001234", wr_data); end
  endtask

  task automatic test_hold_starvation();
    do_reset();
    @(negedge clk);
    hold = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3333_0000;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h3333_0001;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready got %b exp 00", {req0_ready, req1_ready}); end
    @(negedge clk);
    checks++; if (conflict !== 1'b1 || wr_en !== 1'b0) begin
      errors++; $display("FAIL hold_conflict got conflict=%b en=%b exp conflict=1 en=0", conflict, wr_en); end
    @(negedge clk);
    @(negedge clk);
    hold = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL both_starved_rr got %b exp 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_addr = 5'd6;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL after_starve_grant got %b exp 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (conflict !== 1'b0 || wr_addr !== 5'd6) begin
      errors++; $display("FAIL conflict_clear got conflict=%b addr=%0d exp conflict=0 addr=6", conflict, wr_addr); end
    // one requester starved while rr favours the other
    do_reset();
    @(negedge clk);
    hold = 1'b1; req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h8888_0000;
    @(negedge clk);
    @(negedge clk);
    hold = 1'b0; req0_valid = 1'b1; req0_addr = 5'd9;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL starve_override got %b exp 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL starve_followup got %b exp 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_hold_inflight_and_reset();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_00AA;
    @(negedge clk);
    hold = 1'b1; req0_addr = 5'd10;
    #1;
    checks++; if (req0_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 5'd9) begin
      errors++; $display("FAIL hold_inflight got rdy=%b en=%b addr=%0d exp rdy=0 en=1 addr=9", req0_ready, wr_en, wr_addr); end
    @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL hold_no_new_write got %b exp 0", wr_en); end
    hold = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd10) begin
      errors++; $display("FAIL resume_write got en=%b addr=%0d exp en=1 addr=10", wr_en, wr_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd0) begin
      errors++; $display("FAIL midop_reset got en=%b addr=%0d exp en=0 addr=0", wr_en, wr_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0055;
    @(negedge clk);
    req0_valid = 1'b0;
    byp_addr_1 = 5'd7; byp_addr_2 = 5'd0;
    rf_data_1 = 32'h1234_5678; rf_data_2 = 32'hCAFE_F00D;
    #1;
    checks++; if (byp_data_1 !== 32'h0000_0055) begin errors++; $display("FAIL byp1_fwd got %h exp 00000055", byp_data_1); end
    checks++; if (byp_data_2 !== 32'hCAFE_F00D) begin errors++; $display("FAIL byp2_x0 got %h exp cafef00d", byp_data_2); end
    @(negedge clk);
    checks++; if (byp_data_1 !== 32'h1234_5678) begin errors++; $display("FAIL byp1_idle got %h exp 12345678", byp_data_1); end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_hold_starvation();
    test_hold_inflight_and_reset();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wb_arb.md
Name: regfile_wb_arb

Overview:
- Arbitrates the single register-file write port between two writeback requesters: req 0 = ALU/CSR result, req 1 = load unit.
- Uses a valid/ready handshake per requester and round-robin arbitration with starvation protection.
- Drives a registered write (wr_en/wr_addr/wr_data) straight into the register file's write port, one cycle after grant.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of the write port.
- AW, 5, register address width (32 architectural registers; x0 hardwired zero).
- MAX_WAIT, 4, cycles a valid requester may be refused before it gets forced priority (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  pipeline freeze; no new grants while high.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_addr  in  AW  destination register, requester 0.
- req0_data  in  XLEN  write data, requester 0.
- req1_valid  in  1  requester 1 has a write pending.
- req1_ready  out  1  requester 1 granted this cycle.
- req1_addr  in  AW  destination register, requester 1.
- req1_data  in  XLEN  write data, requester 1.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  AW  register-file write address (registered).
- wr_data  out  XLEN  register-file write data (registered).
- conflict  out  1  pulse: both requesters valid, same nonzero addr, same cycle.

Behaviour:
- Reset (async, rst_n low):
  - wr_en=0, wr_addr=0, wr_data=0, conflict=0.
  - Round-robin pointer rr=0 (req 0 preferred); wait counters w0=w1=0.
- Ready outputs are combinational:
  - reqN_ready=1 only when grant N.
  - No grant while hold=1 or while rst_n=0.
  - Transfer occurs when reqN_valid && reqN_ready.
- Grant rule, evaluated when hold=0:
  1. Only one requester valid: grant it.
  2. Both valid and exactly one has wN>=MAX_WAIT: grant that one.
  3. Otherwise grant req rr.
  - After any grant, rr <= index of the non-granted requester.
- Wait counters:
  - wN increments (saturating at 15) each cycle reqN_valid=1 and reqN is not granted, including hold cycles.
  - wN clears on grant or when reqN_valid=0.
- Output stage, every cycle:
  - wr_en <= grant && (granted addr != 0).
  - wr_addr and wr_data load the granted addr/data on grant; otherwise they hold their previous values.
  - Latency: grant in cycle T -> write visible at regfile input in cycle T+1, committed at edge T+2.
  - No backpressure from the register file; one write per cycle maximum.
- x0 writes: handshake completes (ready=1) but wr_en stays 0.
- conflict <= req0_valid && req1_valid && req0_addr==req1_addr && req0_addr!=0, registered one cycle; set regardless of hold.
- Requester rules:
  - Must hold addr/data stable while valid and not ready.
  - Dropping valid without ready is permitted; that requester's counter clears.
- hold asserted while a write is in the output stage: that write still completes next cycle; hold only blocks new grants.
- rst_n asserted mid-operation: the pending output write is discarded (wr_en forced 0 immediately).

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- When defined, adds these ports:
  - byp_addr_1/byp_addr_2 (in, AW)
  - rf_data_1/rf_data_2 (in, XLEN)
  - byp_data_1/byp_data_2 (out, XLEN)
- byp_data_k = wr_data when wr_en && wr_addr==byp_addr_k && byp_addr_k!=0; otherwise rf_data_k. This gives same-cycle forwarding of the in-flight write to the decode read ports.
- When undefined, those ports are absent and no comparators are built.

Test Plan:
- Reset: rst_n=0 with both valid -> readies 0, wr_en=0, wr_addr=0, wr_data=0; after release, first dual-valid cycle grants req0.
- Single request: req1 valid, addr=5, data=0xDEADBEEF -> req1_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
- Round-robin: both valid continuously with distinct addrs -> grants alternate 0,1,0,1; wr_en high every cycle after the first.
- x0 write: req0 valid, addr=0, data=0x1234 -> req0_ready=1, wr_en stays 0.
- Starvation: MAX_WAIT=2, hold=1 for 3 cycles with both valid, then alternating grants -> w0 and w1 saturate above 2; rr decides; conflict pulses if addrs are equal and nonzero.
- Bypass (macro on): grant addr=7, data=0x55; next cycle byp_addr_1=7 -> byp_data_1=0x55; byp_addr_2=0 -> byp_data_2=rf_data_2.
